// File: rtl/qk_core_sequencer.sv
// qk_core_sequencer: generates the 17-bit Q.K core inst word for one run (Q/K write, K load, execute, drain).
module qk_core_sequencer #(
    parameter int total_cycle = 8,
    parameter int col         = 8,
    parameter int gap_k       = 2,
    parameter int gap_l       = 10,
    parameter int gap_e       = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        reuse_k,
    input  logic        data_vld,
    output logic        data_req,
    output logic [16:0] inst,
    output logic        busy,
    output logic        done
);
    typedef enum logic [3:0] {IDLE, WR_Q, WR_K, GAP_K, LOAD, GAP_L, EXEC, GAP_E, DRAIN, DONE} state_t;
    localparam logic [4:0] L_Q   = 5'(total_cycle - 1);
    localparam logic [4:0] L_K   = 5'(col - 1);
    localparam logic [4:0] L_COL = 5'(col);
    localparam logic [4:0] L_LD  = 5'(col + 1);
    localparam logic [4:0] L_GK  = 5'(gap_k - 1);
    localparam logic [4:0] L_GL  = 5'(gap_l - 1);
    localparam logic [4:0] L_GE  = 5'(gap_e - 1);
    state_t     r_state, w_next;
    logic [4:0] r_cnt, w_cnt_next;
    logic       r_reuse, w_hold, w_krd;
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_reuse <= 1'b0;
        end else begin
            r_state <= w_next;
            r_cnt   <= w_cnt_next;
            if (r_state == IDLE && start) r_reuse <= reuse_k;
        end
    end
    // cnt holds while idle or while a write state waits for data; it clears on any state change.
    always_comb begin
        w_next   = r_state;
        w_hold   = 1'b0;
        w_krd    = 1'b0;
        inst     = '0;
        data_req = 1'b0;
        done     = 1'b0;
        busy     = r_state != IDLE;
        case (r_state)
            IDLE: begin
                w_hold = 1'b1;
                if (start) w_next = WR_Q;
            end
            WR_Q: begin
                data_req      = 1'b1;
                w_hold        = !data_vld;
                inst[4]       = data_vld;
                inst[15:12]   = data_vld ? r_cnt[3:0] : 4'd0;
                if (data_vld && r_cnt == L_Q) w_next = r_reuse ? GAP_L : WR_K;
            end
            WR_K: begin
                data_req      = 1'b1;
                w_hold        = !data_vld;
                inst[2]       = data_vld;
                inst[15:12]   = data_vld ? r_cnt[3:0] : 4'd0;
                if (data_vld && r_cnt == L_K) w_next = GAP_K;
            end
            GAP_K: if (r_cnt == L_GK) w_next = LOAD;
            LOAD: begin
                w_krd       = r_cnt != 5'd0 && r_cnt <= L_COL;
                inst[6]     = 1'b1;
                inst[3]     = w_krd;
                inst[15:12] = w_krd ? 4'(r_cnt - 5'd1) : 4'd0;
                if (r_cnt == L_LD) w_next = GAP_L;
            end
            GAP_L: if (r_cnt == L_GL) w_next = EXEC;
            EXEC: begin
                inst[7]     = 1'b1;
                inst[5]     = 1'b1;
                inst[15:12] = r_cnt[3:0];
                if (r_cnt == L_Q) w_next = GAP_E;
            end
            GAP_E: if (r_cnt == L_GE) w_next = DRAIN;
            DRAIN: begin
                inst[16]   = 1'b1;
                inst[0]    = 1'b1;
                inst[11:8] = r_cnt[3:0];
                if (r_cnt == L_Q) w_next = DONE;
            end
            DONE: begin
                done   = 1'b1;
                w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
        w_cnt_next = (w_next != r_state) ? 5'd0 : w_hold ? r_cnt : r_cnt + 5'd1;
    end
endmodule
